neuron_mac_sequencer: RTL and testbench

NEURON_MAC_SEQUENCER -- requirements
Module: neuron_mac_sequencer

---
 rtl/neuron_mac_sequencer.sv | 130 +++++++++++++
 tb/tb_neuron_mac_sequencer.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_mac_sequencer.sv
// Single-neuron MAC sequencer: reads N (x,w) byte pairs from RAM, accumulates x*w,
// writes sat8(acc >> SHIFT) back to RAM. Latency: write in cycle 2N+1, done in 2N+2.
// No backpressure: RAM is combinational-read, start is ignored while busy.
module neuron_mac_sequencer #(
  parameter int SHIFT = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] base_addr,
  input  logic [7:0] count,
  input  logic [7:0] out_addr,
  output logic       busy,
  output logic       done,
  output logic [7:0] result,
  output logic [7:0] ram_read_address,
  output logic       ram_oe,
  input  logic [7:0] ram_read_data,
  output logic [7:0] ram_write_address,
  output logic [7:0] ram_write_data,
  output logic       ram_wre
);

  typedef enum logic [2:0] {
    IDLE,
    READ_X,
    READ_W,
    WRITE,
    DONE
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [7:0]  base_q;
  logic [7:0]  n_q;
  logic [7:0]  out_q;
  logic [7:0]  idx_q;
  logic [7:0]  x_q;
  logic [23:0] acc_q;
  logic [23:0] acc_shr;
  logic [15:0] prod;
  logic [7:0]  sat_val;
  logic        last_pair;

  // Product of the latched x and the weight currently on the read bus.
  assign prod      = x_q * ram_read_data;
  assign acc_shr   = acc_q >> SHIFT;
  assign sat_val   = (acc_shr > 24'd255) ? 8'd255 : acc_shr[7:0];
  // Widened compare so i+1 cannot wrap when N=255.
  assign last_pair = ({1'b0, idx_q} + 9'd1) >= {1'b0, n_q};

  // State register; reset aborts any evaluation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and RAM/handshake outputs, all decoded from the current state.
  always_comb begin
    state_nxt         = state;
    busy              = 1'b1;
    done              = 1'b0;
    ram_oe            = 1'b0;
    ram_read_address  = 8'd0;
    ram_wre           = 1'b0;
    ram_write_address = 8'd0;
    ram_write_data    = 8'd0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = (count != 8'd0) ? READ_X : WRITE;
      end
      READ_X: begin
        ram_oe           = 1'b1;
        ram_read_address = base_q + idx_q;
        state_nxt        = READ_W;
      end
      READ_W: begin
        ram_oe           = 1'b1;
        ram_read_address = base_q + n_q + idx_q;
        state_nxt        = last_pair ? WRITE : READ_X;
      end
      WRITE: begin
        ram_wre           = 1'b1;
        ram_write_address = out_q;
        ram_write_data    = sat_val;
        state_nxt         = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand latching, accumulation and result capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_q <= 8'd0;
      n_q    <= 8'd0;
      out_q  <= 8'd0;
      idx_q  <= 8'd0;
      x_q    <= 8'd0;
      acc_q  <= 24'd0;
      result <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            base_q <= base_addr;
            n_q    <= count;
            out_q  <= out_addr;
            acc_q  <= 24'd0;
            idx_q  <= 8'd0;
          end
        end
        READ_X: x_q <= ram_read_data;
        READ_W: begin
          acc_q <= acc_q + {8'd0, prod};
          idx_q <= idx_q + 8'd1;
        end
        WRITE:   result <= sat_val;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_mac_sequencer.sv
module tb_neuron_mac_sequencer;

  localparam int SHIFT = 0;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] base_addr;
  logic [7:0] count;
  logic [7:0] out_addr;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic [7:0] ram_read_address;
  logic       ram_oe;
  logic [7:0] ram_read_data;
  logic [7:0] ram_write_address;
  logic [7:0] ram_write_data;
  logic       ram_wre;

  logic [7:0] mem [0:255];
  logic [7:0] img [0:255];
  logic       load_req;

  int tests = 0;
  int fails = 0;

  neuron_mac_sequencer #(.SHIFT(SHIFT)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .base_addr(base_addr),
    .count(count),
    .out_addr(out_addr),
    .busy(busy),
    .done(done),
    .result(result),
    .ram_read_address(ram_read_address),
    .ram_oe(ram_oe),
    .ram_read_data(ram_read_data),
    .ram_write_address(ram_write_address),
    .ram_write_data(ram_write_data),
    .ram_wre(ram_wre)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM: combinational read, write on the clock edge; bench images are copied in on request.
  assign ram_read_data = mem[ram_read_address];
  always @(posedge clk) begin
    if (load_req) begin
      for (int i = 0; i < 256; i++) mem[i] = img[i];
    end else if (ram_wre) begin
      mem[ram_write_address] = ram_write_data;
    end
  end

  task automatic load_ram();
    @(negedge clk);
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
  endtask

  // Reference: dot product over the image with mod-256 addressing, shift, saturate.
  function automatic logic [7:0] model(input logic [7:0] b, input logic [7:0] n);
    longint s;
    logic [7:0] xa;
    logic [7:0] wa;
    s = 0;
    for (int i = 0; i < int'(n); i++) begin
      xa = 8'(int'(b) + i);
      wa = 8'(int'(b) + int'(n) + i);
      s += longint'(img[xa]) * longint'(img[wa]);
    end
    s = s >> SHIFT;
    return (s > 255) ? 8'd255 : 8'(s);
  endfunction

  // One evaluation with per-cycle protocol checks; inputs are scrambled while busy,
  // and optionally a stray start (with a different base) is pulsed at cycle inj.
  task automatic run_eval(input logic [7:0] b, input logic [7:0] n, input logic [7:0] o,
                          input int inj, input logic [7:0] inj_base, input string name);
    logic [7:0] expv;
    logic [7:0] ea;
    int nn;
    int bad_rd;
    int bad_busy;
    int bad_wr;
    int n_wr;
    int wr_cyc;
    int n_done;
    int done_cyc;
    nn = int'(n);
    bad_rd = 0; bad_busy = 0; bad_wr = 0; n_wr = 0; wr_cyc = -1; n_done = 0; done_cyc = -1;
    load_ram();
    expv = model(b, n);
    @(negedge clk);
    base_addr = b; count = n; out_addr = o; start = 1'b1;
    for (int k = 1; k <= 2 * nn + 3; k++) begin
      @(negedge clk);
      if (k <= 2 * nn) begin
        if (k % 2 == 1) ea = 8'(int'(b) + (k - 1) / 2);
        else            ea = 8'(int'(b) + nn + (k - 2) / 2);
        if (ram_oe !== 1'b1 || ram_read_address !== ea) bad_rd++;
      end else begin
        if (ram_oe !== 1'b0 || ram_read_address !== 8'd0) bad_rd++;
      end
      if (ram_wre === 1'b1) begin
        n_wr++;
        wr_cyc = k;
        if (ram_write_address !== o || ram_write_data !== expv) bad_wr++;
      end
      if (done === 1'b1) begin
        n_done++;
        done_cyc = k;
      end
      if (busy !== (k <= 2 * nn + 2)) bad_busy++;
      if (k == inj) begin
        start = 1'b1;
        base_addr = inj_base;
      end else begin
        start = 1'b0;
        base_addr = 8'($urandom);
      end
      count = 8'($urandom);
      out_addr = 8'($urandom);
    end
    start = 1'b0;
    tests++;
    if (bad_rd != 0) begin
      fails++;
      $display("FAIL %s reads: %0d bad read cycles, want 0", name, bad_rd);
    end
    tests++;
    if (n_wr != 1 || wr_cyc != 2 * nn + 1 || bad_wr != 0) begin
      fails++;
      $display("FAIL %s write: %0d writes at cycle %0d (%0d bad), want 1 at cycle %0d",
               name, n_wr, wr_cyc, bad_wr, 2 * nn + 1);
    end
    tests++;
    if (n_done != 1 || done_cyc != 2 * nn + 2) begin
      fails++;
      $display("FAIL %s done: %0d pulses, last at cycle %0d, want 1 at cycle %0d",
               name, n_done, done_cyc, 2 * nn + 2);
    end
    tests++;
    if (bad_busy != 0) begin
      fails++;
      $display("FAIL %s busy: %0d wrong cycles, want 0", name, bad_busy);
    end
    tests++;
    if (mem[o] !== expv) begin
      fails++;
      $display("FAIL %s ram[%0d]: got %0d want %0d", name, o, mem[o], expv);
    end
    tests++;
    if (result !== expv) begin
      fails++;
      $display("FAIL %s result: got %0d want %0d", name, result, expv);
    end
  endtask

  task automatic set_basic_image();
    for (int i = 0; i < 256; i++) img[i] = 8'($urandom);
    img[0] = 8'd10; img[1] = 8'd10; img[2] = 8'd11; img[3] = 8'd11;
    img[4] = 8'd2;  img[5] = 8'd3;  img[6] = 8'd2;  img[7] = 8'd3;
  endtask

  task automatic test_reset();
    int waited;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if ({busy, done, result, ram_oe, ram_wre, ram_read_address, ram_write_address,
         ram_write_data} !== 36'd0) begin
      fails++;
      $display("FAIL reset_outputs: busy=%b done=%b result=%0d oe=%b wre=%b ra=%0d wa=%0d wd=%0d, want all 0",
               busy, done, result, ram_oe, ram_wre, ram_read_address, ram_write_address,
               ram_write_data);
    end
    set_basic_image();
    load_ram();
    @(negedge clk);
    rst = 1'b0; start = 1'b1; base_addr = 8'd0; count = 8'd4; out_addr = 8'd8;
    @(negedge clk);
    start = 1'b0;
    tests++;
    if (busy !== 1'b1 || ram_oe !== 1'b1 || ram_read_address !== 8'd0) begin
      fails++;
      $display("FAIL start_after_reset: busy=%b oe=%b ra=%0d, want 1 1 0",
               busy, ram_oe, ram_read_address);
    end
    waited = 0;
    while (busy === 1'b1 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    tests++;
    if (waited >= 40 || result !== 8'd105) begin
      fails++;
      $display("FAIL first_eval: result=%0d after %0d cycles, want 105 within 40", result, waited);
    end
  endtask

  task automatic test_basic();
    set_basic_image();
    run_eval(8'd0, 8'd4, 8'd8, -1, 8'd0, "basic");
    tests++;
    if (mem[8] !== 8'd105) begin
      fails++;
      $display("FAIL basic_const: ram[8]=%0d want 105", mem[8]);
    end
  endtask

  task automatic test_saturate();
    img[0] = 8'd200; img[1] = 8'd200;
    run_eval(8'd0, 8'd1, 8'd9, -1, 8'd0, "saturate");
    tests++;
    if (mem[9] !== 8'd255) begin
      fails++;
      $display("FAIL saturate_const: ram[9]=%0d want 255", mem[9]);
    end
  endtask

  task automatic test_zero_count();
    img[12] = 8'hAA;
    run_eval(8'd37, 8'd0, 8'd12, -1, 8'd0, "zero_count");
    tests++;
    if (mem[12] !== 8'd0) begin
      fails++;
      $display("FAIL zero_const: ram[12]=%0d want 0", mem[12]);
    end
  endtask

  task automatic test_wrap();
    img[255] = 8'd7; img[0] = 8'd6;
    run_eval(8'd255, 8'd1, 8'd40, -1, 8'd0, "wrap");
    tests++;
    if (result !== 8'd42) begin
      fails++;
      $display("FAIL wrap_const: result=%0d want 42", result);
    end
  endtask

  task automatic test_reset_abort();
    int n_wre;
    int n_done;
    set_basic_image();
    img[8] = 8'h5A;
    load_ram();
    @(negedge clk);
    base_addr = 8'd0; count = 8'd4; out_addr = 8'd8; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    tests++;
    if (busy !== 1'b0 || ram_oe !== 1'b0 || done !== 1'b0 || result !== 8'd0) begin
      fails++;
      $display("FAIL abort_immediate: busy=%b oe=%b done=%b result=%0d, want 0 0 0 0",
               busy, ram_oe, done, result);
    end
    @(negedge clk);
    rst = 1'b0;
    n_wre = 0; n_done = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (ram_wre === 1'b1) n_wre++;
      if (done === 1'b1) n_done++;
    end
    tests++;
    if (n_wre != 0 || n_done != 0 || mem[8] !== 8'h5A || result !== 8'd0) begin
      fails++;
      $display("FAIL abort_quiet: wre=%0d done=%0d ram[8]=%0d result=%0d, want 0 0 90 0",
               n_wre, n_done, mem[8], result);
    end
    run_eval(8'd0, 8'd4, 8'd8, -1, 8'd0, "after_abort");
  endtask

  task automatic test_start_ignored();
    set_basic_image();
    run_eval(8'd0, 8'd4, 8'd8, 3, 8'd4, "start_ignored");
    tests++;
    if (result !== 8'd105) begin
      fails++;
      $display("FAIL ignored_const: result=%0d want 105", result);
    end
  endtask

  task automatic test_start_held();
    logic bq [1:12];
    int first_idle;
    int waited;
    img[0] = 8'd3; img[1] = 8'd5;
    load_ram();
    @(negedge clk);
    base_addr = 8'd0; count = 8'd1; out_addr = 8'd20; start = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      bq[k] = busy;
    end
    first_idle = -1;
    for (int k = 12; k >= 1; k--) if (bq[k] === 1'b0) first_idle = k;
    tests++;
    if (first_idle != 5 || bq[6] !== 1'b1 || result !== 8'd15) begin
      fails++;
      $display("FAIL start_held: first idle cycle %0d busy@6=%b result=%0d, want 5 1 15",
               first_idle, bq[6], result);
    end
    start = 1'b0;
    waited = 0;
    while (busy === 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL held_release: busy=%b after %0d cycles, want 0", busy, waited);
    end
  endtask

  task automatic test_random();
    logic [7:0] b;
    logic [7:0] n;
    logic [7:0] o;
    for (int it = 0; it < 16; it++) begin
      for (int i = 0; i < 256; i++)
        img[i] = (it % 2 == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom);
      b = 8'($urandom);
      n = (it == 15) ? 8'd255 : 8'($urandom_range(0, 10));
      o = 8'($urandom);
      run_eval(b, n, o, -1, 8'd0, "random");
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; base_addr = 8'd0; count = 8'd0; out_addr = 8'd0;
    load_req = 1'b0;
    for (int i = 0; i < 256; i++) img[i] = 8'd0;
    test_reset();
    test_basic();
    test_saturate();
    test_zero_count();
    test_wrap();
    test_reset_abort();
    test_start_ignored();
    test_start_held();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
